// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: state encoding and constants shared by the flash configuration loader.
// Build option: FPGA_CFG_CHECKSUM_EN adds the CHK state (trailer checksum word).
package fpga_cfg_pkg;

  localparam logic [7:0]  READ_OPCODE = 8'h03;
  localparam logic [15:0] HDR_MAGIC   = 16'hFC25;
  localparam int          WORD_W      = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    PUSH = 3'd4,
`ifdef FPGA_CFG_CHECKSUM_EN
    CHK  = 3'd5,
`endif
    DONE = 3'd6,
    ERR  = 3'd7
  } state_t;

  // A load owns the flash bus in every state except IDLE, DONE and ERR.
  function automatic logic is_active(state_t s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

endpackage

// File: rtl/fpga_cfg_spi_shifter.sv
// fpga_cfg_spi_shifter: one 32-bit full-duplex SPI mode-0 transfer, MSB first.
// SCLK idles low, MISO is captured on the cycle SCLK rises, MOSI moves after each fall.
module fpga_cfg_spi_shifter
  import fpga_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              hold_i,
  input  logic [WORD_W-1:0] tx_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rx_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  // The start cycle already counts toward the first low half-period.
  localparam logic [7:0] DIV_INIT = (CLK_DIV > 1) ? 8'd1 : 8'd0;

  logic              busy_q;
  logic              sclk_q;
  logic              done_q;
  logic [7:0]        div_q;
  logic [4:0]        bit_q;
  logic [WORD_W-1:0] tx_q;
  logic [WORD_W-1:0] rx_q;

  // Half-period divider, SCLK toggling and the two shift registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        busy_q <= 1'b0;
        sclk_q <= 1'b0;
        div_q  <= '0;
        bit_q  <= '0;
        tx_q   <= '0;
      end else if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          sclk_q <= 1'b0;
          div_q  <= DIV_INIT;
          bit_q  <= '0;
          tx_q   <= tx_i;
        end
      end else if (!hold_i) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[WORD_W-2:0], miso_i};
          end else begin
            sclk_q <= 1'b0;
            if (bit_q == 5'd31) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              tx_q   <= '0;
            end else begin
              bit_q <= bit_q + 5'd1;
              tx_q  <= {tx_q[WORD_W-2:0], 1'b0};
            end
          end
        end else begin
          div_q <= div_q + 8'd1;
        end
      end
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = tx_q[WORD_W-1];
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: reads a configuration image from SPI flash and streams it to the fabric.
// Build option: FPGA_CFG_CHECKSUM_EN reads a trailer word that must be the negated word sum.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int SLOT_SHIFT = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic              trigger_i,
  input  logic [3:0]        slot_i,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic              mosi_o,
  output logic              sclk_en_o,
  output logic              cs_n_en_o,
  output logic              mosi_en_o,
  input  logic              miso_i,
  output logic [WORD_W-1:0] cfg_data_o,
  output logic              cfg_valid_o,
  input  logic              cfg_ready_i,
  output logic              busy_o,
  output logic              configured_o,
  output logic              error_o
);

  state_t            state_q, state_d;
  logic              trig_q;
  logic [3:0]        slot_q, slot_d;
  logic [15:0]       left_q, left_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              configured_q, configured_d;
  logic              error_q, error_d;
`ifdef FPGA_CFG_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
`endif

  logic              active;
  logic              xfer_state;
  logic              spi_start, spi_clear, spi_busy, spi_done, spi_sclk, spi_mosi;
  logic [WORD_W-1:0] spi_tx, spi_rx;
  logic [23:0]       flash_addr;

  assign flash_addr = 24'({28'd0, slot_q} << SLOT_SHIFT);
  assign active     = is_active(state_q);

  // State and datapath registers; trig_q resets high so a trigger held through reset is not an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      trig_q       <= 1'b1;
      slot_q       <= '0;
      left_q       <= '0;
      data_q       <= '0;
      configured_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= trigger_i;
      slot_q       <= slot_d;
      left_q       <= left_d;
      data_q       <= data_d;
      configured_q <= configured_d;
      error_q      <= error_d;
`ifdef FPGA_CFG_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // Next-state logic: sequence command, header, data/push pairs, optional trailer, then finish.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    left_d       = left_q;
    data_d       = data_q;
    configured_d = configured_q;
    error_d      = error_q;
`ifdef FPGA_CFG_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    spi_tx       = '0;
    xfer_state   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_i && trigger_i && !trig_q) begin
          state_d      = CMD;
          slot_d       = slot_i;
          configured_d = 1'b0;
          error_d      = 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      CMD: begin
        xfer_state = 1'b1;
        spi_tx     = {READ_OPCODE, flash_addr};
        if (spi_done) state_d = HDR;
      end
      HDR: begin
        xfer_state = 1'b1;
        if (spi_done) begin
          if (spi_rx[31:16] != HDR_MAGIC || spi_rx[15:0] == 16'd0) begin
            state_d = ERR;
          end else begin
            left_d  = spi_rx[15:0];
            state_d = DATA;
          end
        end
      end
      DATA: begin
        xfer_state = 1'b1;
        if (spi_done) begin
          data_d  = spi_rx;
          state_d = PUSH;
        end
      end
      PUSH: begin
        if (cfg_ready_i) begin
`ifdef FPGA_CFG_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (left_q == 16'd1) begin
`ifdef FPGA_CFG_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else begin
            left_d  = left_q - 16'd1;
            state_d = DATA;
          end
        end
      end
`ifdef FPGA_CFG_CHECKSUM_EN
      CHK: begin
        xfer_state = 1'b1;
        if (spi_done) state_d = (spi_rx == (~sum_q + 32'd1)) ? DONE : ERR;
      end
`endif
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (active && !mode_i) state_d = ERR;
    if (state_d == DONE) configured_d = 1'b1;
    if (state_d == ERR)  error_d      = 1'b1;
  end

  assign spi_start = xfer_state && !spi_busy && !spi_done;
  assign spi_clear = !is_active(state_d);

  fpga_cfg_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (spi_clear),
    .start_i (spi_start),
    .hold_i  (state_q == PUSH),
    .tx_i    (spi_tx),
    .miso_i  (miso_i),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .busy_o  (spi_busy),
    .done_o  (spi_done),
    .rx_o    (spi_rx)
  );

  assign busy_o       = active;
  assign cs_n_o       = !active;
  assign sclk_o       = spi_sclk && active;
  assign mosi_o       = spi_mosi && active;
  assign sclk_en_o    = active;
  assign cs_n_en_o    = active;
  assign mosi_en_o    = active;
  assign cfg_data_o   = data_q;
  assign cfg_valid_o  = (state_q == PUSH) && mode_i;
  assign configured_o = configured_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: self-checking bench with a bit-level SPI flash model and a word scoreboard.
// Build option: FPGA_CFG_CHECKSUM_EN must match the RTL build; it enables the trailer tests.
module tb_fpga_cfg_loader;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst, mode, trigger, miso, cfg_ready;
  logic [3:0]  slot;
  logic        sclk_o, cs_n_o, mosi_o, sclk_en_o, cs_n_en_o, mosi_en_o;
  logic [31:0] cfg_data_o;
  logic        cfg_valid_o, busy_o, configured_o, error_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_cfg_loader #(
    .CLK_DIV    (CLK_DIV),
    .SLOT_SHIFT (20)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_i       (mode),
    .trigger_i    (trigger),
    .slot_i       (slot),
    .sclk_o       (sclk_o),
    .cs_n_o       (cs_n_o),
    .mosi_o       (mosi_o),
    .sclk_en_o    (sclk_en_o),
    .cs_n_en_o    (cs_n_en_o),
    .mosi_en_o    (mosi_en_o),
    .miso_i       (miso),
    .cfg_data_o   (cfg_data_o),
    .cfg_valid_o  (cfg_valid_o),
    .cfg_ready_i  (cfg_ready),
    .busy_o       (busy_o),
    .configured_o (configured_o),
    .error_o      (error_o)
  );

  // Flash model: word 0 is the command phase, then header, data words and optional trailer.
  logic [31:0] flash_mem [0:15];
  int          flash_len = 0;
  int          bit_idx = 0;
  logic [31:0] dw [0:7];

  always @(negedge sclk_o or posedge cs_n_o)
    if (cs_n_o) bit_idx <= 0;
    else        bit_idx <= bit_idx + 1;

  always_comb begin
    miso = 1'b0;
    if ((bit_idx / 32) < flash_len) miso = flash_mem[(bit_idx / 32)][31 - (bit_idx % 32)];
  end

  // Command capture and SCLK rising-edge count for each chip-select window.
  logic [31:0] cmd_cap = '0;
  int          rise_cnt = 0;
  always @(posedge sclk_o or negedge cs_n_o)
    if (sclk_o) begin
      if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], mosi_o};
      rise_cnt <= rise_cnt + 1;
    end else begin
      rise_cnt <= 0;
      cmd_cap  <= '0;
    end

  // Fabric-side monitor: records every accepted word and every valid cycle.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          valid_cycles = 0;
  always @(negedge clk) begin
    if (cfg_valid_o) valid_cycles = valid_cycles + 1;
    if (cfg_valid_o && cfg_ready) got_q.push_back(cfg_data_o);
  end

  function automatic logic [31:0] sum_words(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s = s + dw[i];
    return s;
  endfunction

  task automatic setup_flash(input logic [31:0] hdr, input int n, input logic [31:0] bias,
                             input bit push_exp);
    flash_mem[0] = 32'h0;
    flash_mem[1] = hdr;
    for (int i = 0; i < n; i++) begin
      flash_mem[2 + i] = dw[i];
      if (push_exp) exp_q.push_back(dw[i]);
    end
    flash_mem[2 + n] = ~sum_words(n) + 32'd1 + bias;
`ifdef FPGA_CFG_CHECKSUM_EN
    flash_len = 3 + n;
`else
    flash_len = 2 + n;
`endif
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) dw[i] = $urandom;
  endtask

  task automatic start_load(input logic [3:0] s);
    @(posedge clk); #1;
    slot = s;
    trigger = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (configured_o || error_o) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; trigger = 1'b0; slot = 4'd0; cfg_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk_o, cs_n_o, mosi_o} !== 3'b010) begin
      errors++; $display("[TB] FAIL reset_spi: got %b required 010", {sclk_o, cs_n_o, mosi_o});
    end
    checks++;
    if ({sclk_en_o, cs_n_en_o, mosi_en_o} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_en: got %b required 000", {sclk_en_o, cs_n_en_o, mosi_en_o});
    end
    checks++;
    if ({busy_o, configured_o, error_o, cfg_valid_o} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b required 0000",
                         {busy_o, configured_o, error_o, cfg_valid_o});
    end
    checks++;
    if (cfg_data_o !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h required 0", cfg_data_o);
    end
    trigger = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || cs_n_o !== 1'b1) begin
      errors++; $display("[TB] FAIL held_trigger_start: busy %b cs_n %b required 0 1", busy_o, cs_n_o);
    end
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_load();
    bit to;
    int base = got_q.size();
    fill_random(4);
    setup_flash(32'hFC250004, 4, 32'h0, 1'b1);
    cfg_ready = 1'b1;
    start_load(4'd3);
    @(negedge clk);
    checks++;
    if ({cs_n_o, sclk_en_o, cs_n_en_o, mosi_en_o, busy_o} !== 5'b01111) begin
      errors++; $display("[TB] FAIL load_pads: got %b required 01111",
                         {cs_n_o, sclk_en_o, cs_n_en_o, mosi_en_o, busy_o});
    end
    wait_end(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL basic_timeout: load never finished"); end
    checks++;
    if (cmd_cap !== 32'h03300000) begin
      errors++; $display("[TB] FAIL basic_cmd: got %h required 03300000", cmd_cap);
    end
    checks++;
    if ({configured_o, error_o, busy_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL basic_flags: got %b required 100", {configured_o, error_o, busy_o});
    end
`ifdef FPGA_CFG_CHECKSUM_EN
    checks++;
    if (rise_cnt != 7 * 32) begin errors++; $display("[TB] FAIL basic_sclk: got %0d required %0d", rise_cnt, 7 * 32); end
`else
    checks++;
    if (rise_cnt != 6 * 32) begin errors++; $display("[TB] FAIL basic_sclk: got %0d required %0d", rise_cnt, 6 * 32); end
`endif
    checks++;
    if (got_q.size() - base != 4) begin
      errors++; $display("[TB] FAIL basic_count: got %0d required 4", got_q.size() - base);
    end
    for (int i = base; i < got_q.size(); i++) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (got_q[i] !== e) begin errors++; $display("[TB] FAIL basic_word%0d: got %h required %h", i - base, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_bad_header();
    bit to;
    logic [31:0] hdrs [2];
    hdrs[0] = 32'h12340004;
    hdrs[1] = 32'hFC250000;
    for (int h = 0; h < 2; h++) begin
      int v0 = valid_cycles;
      fill_random(4);
      setup_flash(hdrs[h], 4, 32'h0, 1'b0);
      start_load(4'd1);
      wait_end(to);
      @(negedge clk);
      checks++;
      if (to || {error_o, configured_o, cs_n_o} !== 3'b101) begin
        errors++; $display("[TB] FAIL badhdr%0d_flags: got err/cfg/cs_n %b required 101", h,
                           {error_o, configured_o, cs_n_o});
      end
      checks++;
      if (valid_cycles != v0) begin errors++; $display("[TB] FAIL badhdr%0d_valid: got %0d valid cycles required 0", h, valid_cycles - v0); end
      checks++;
      if (rise_cnt != 64) begin errors++; $display("[TB] FAIL badhdr%0d_sclk: got %0d required 64", h, rise_cnt); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int base = got_q.size();
    int bad = 0;
    int n = 0;
    logic [31:0] held;
    fill_random(4);
    setup_flash(32'hFC250004, 4, 32'h0, 1'b1);
    cfg_ready = 1'b1;
    start_load(4'd2);
    while (got_q.size() == base && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cfg_ready = 1'b0;
    n = 0;
    while (!cfg_valid_o && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (!cfg_valid_o) begin errors++; $display("[TB] FAIL stall_valid: got 0 required 1"); end
    held = cfg_data_o;
    checks++;
    if (held !== dw[1]) begin errors++; $display("[TB] FAIL stall_word: got %h required %h", held, dw[1]); end
    repeat (50) begin
      @(negedge clk);
      if (cfg_data_o !== held || sclk_o !== 1'b0 || cfg_valid_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d bad cycles required 0", bad); end
    @(posedge clk); #1;
    cfg_ready = 1'b1;
    wait_end(to);
    checks++;
    if (to || configured_o !== 1'b1 || got_q.size() - base != 4) begin
      errors++; $display("[TB] FAIL stall_finish: configured %b words %0d required 1 4", configured_o, got_q.size() - base);
    end
    for (int i = base; i < got_q.size(); i++) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (got_q[i] !== e) begin errors++; $display("[TB] FAIL stall_word%0d: got %h required %h", i - base, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_load();
    bit to;
    int n = 0;
    int base;
    fill_random(4);
    setup_flash(32'hFC250004, 4, 32'h0, 1'b0);
    cfg_ready = 1'b0;
    start_load(4'd5);
    while (!cfg_valid_o && n < 5000) begin @(negedge clk); n++; end
    base = got_q.size();
    rst = 1'b1;
    #1;
    checks++;
    if ({sclk_o, cs_n_o, mosi_o, busy_o, cfg_valid_o, sclk_en_o, cs_n_en_o, mosi_en_o} !== 8'b01000000
        || cfg_data_o !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_idle: got %b data %h required 01000000 data 0",
                         {sclk_o, cs_n_o, mosi_o, busy_o, cfg_valid_o, sclk_en_o, cs_n_en_o, mosi_en_o}, cfg_data_o);
    end
    cfg_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (got_q.size() != base || sclk_o !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_quiet: got %0d transfers sclk %b required 0 0", got_q.size() - base, sclk_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    fill_random(4);
    setup_flash(32'hFC250004, 4, 32'h0, 1'b1);
    start_load(4'd5);
    wait_end(to);
    checks++;
    if (to || configured_o !== 1'b1 || got_q.size() - base != 4) begin
      errors++; $display("[TB] FAIL reload_finish: configured %b words %0d required 1 4", configured_o, got_q.size() - base);
    end
    for (int i = base; i < got_q.size(); i++) begin
      logic [31:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (got_q[i] !== e) begin errors++; $display("[TB] FAIL reload_word%0d: got %h required %h", i - base, got_q[i], e); end
    end
    exp_q.delete();
  endtask

  task automatic test_retrigger_and_abort();
    bit to;
    int n = 0;
    int base = got_q.size();
    fill_random(4);
    setup_flash(32'hFC250004, 4, 32'h0, 1'b0);
    cfg_ready = 1'b1;
    start_load(4'd7);
    repeat (40) @(negedge clk);
    start_load(4'd0);
    wait_end(to);
    repeat (20) @(negedge clk);
    checks++;
    if (to || {configured_o, busy_o} !== 2'b10 || got_q.size() - base != 4) begin
      errors++; $display("[TB] FAIL retrigger: configured/busy %b words %0d required 10 4",
                         {configured_o, busy_o}, got_q.size() - base);
    end
    base = got_q.size();
    start_load(4'd7);
    while (got_q.size() == base && n < 5000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    mode = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b required 0", cfg_valid_o); end
    @(negedge clk);
    checks++;
    if ({error_o, configured_o, cs_n_o, busy_o} !== 4'b1010) begin
      errors++; $display("[TB] FAIL abort_state: got err/cfg/cs_n/busy %b required 1010",
                         {error_o, configured_o, cs_n_o, busy_o});
    end
    @(posedge clk); #1;
    mode = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({error_o, busy_o, sclk_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL abort_hold: got err/busy/sclk %b required 100", {error_o, busy_o, sclk_o});
    end
  endtask

`ifdef FPGA_CFG_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    dw[0] = 32'd1; dw[1] = 32'd2; dw[2] = 32'd3;
    setup_flash(32'hFC250003, 3, 32'h0, 1'b0);
    checks++;
    if (flash_mem[5] !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL chk_trailer_setup: got %h required FFFFFFFA", flash_mem[5]); end
    start_load(4'd4);
    wait_end(to);
    checks++;
    if (to || {configured_o, error_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL chk_good: got cfg/err %b required 10", {configured_o, error_o});
    end
    setup_flash(32'hFC250003, 3, 32'h1, 1'b0);
    start_load(4'd4);
    wait_end(to);
    checks++;
    if (to || {configured_o, error_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL chk_bad: got cfg/err %b required 01", {configured_o, error_o});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_bad_header();
    test_backpressure();
    test_reset_mid_load();
    test_retrigger_and_abort();
`ifdef FPGA_CFG_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCLK half-period in clk_i cycles, legal range 1..255.
REQ-002 SHALL have parameter SLOT_SHIFT, default 20: flash byte-address bits per slot, giving 1 MiB per slot.
REQ-003 SHALL have the following ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  single system clock.
- rst_i  in  1  asynchronous active-high reset.
- mode_i  in  1  1 = self-load from flash; 0 = loader disabled.
- trigger_i  in  1  start request, rising-edge sensitive.
- slot_i  in  4  flash slot index, sampled at start.
- sclk_o, cs_n_o, mosi_o  out  1 each  SPI master outputs.
- sclk_en_o, cs_n_en_o, mosi_en_o  out  1 each  pad output enables.
- miso_i  in  1  SPI data from flash.
- cfg_data_o  out  32  configuration word to the fabric.
- cfg_valid_o  out  1  cfg_data_o is valid.
- cfg_ready_i  in  1  fabric accepts the word.
- busy_o  out  1  a load is in progress.
- configured_o  out  1  last load completed successfully.
- error_o  out  1  last load failed.

Function
REQ-004 SHALL start a load when mode_i=1, state is IDLE and trigger_i goes 0->1 (edge detected on a registered copy); trigger_i is ignored in every other state.
REQ-005 SHALL, at start, latch slot_i; set busy_o=1; clear configured_o and error_o; drive all three pad enables to 1 until the load finishes.
REQ-006 SHALL use the states IDLE -> CMD -> HDR -> DATA <-> PUSH -> [CHK] -> DONE, plus ERR. DONE and ERR each last one cycle, then return to IDLE.
REQ-007 CMD SHALL shift out 32 bits MSB-first: opcode 0x03, then the 24-bit address {slot, SLOT_SHIFT zero bits}, truncated to 24 bits.
REQ-008 SPI SHALL run in mode 0:
- sclk_o idles low.
- mosi_o changes after a falling edge.
- miso_i is sampled on the clk_i cycle of each rising edge.
- cs_n_o goes low one half-period before the first rising edge and stays low for the whole load.
REQ-009 HDR SHALL read one 32-bit word: bits[31:16] must equal 0xFC25 and bits[15:0] give the word count N. Either a magic mismatch or N=0 SHALL go to ERR.
REQ-010 DATA SHALL shift in one 32-bit word, then PUSH SHALL assert cfg_valid_o holding that word stable until cfg_ready_i=1.
- SCLK is held low during PUSH (backpressure).
- The word transfers on the cycle where valid and ready are both high.
REQ-011 After the N-th transfer the block SHALL go to CHK (if REQ-020 applies) or DONE; the word counter is 16 bits and SHALL NOT wrap.
REQ-012 DONE SHALL set configured_o=1; ERR SHALL set error_o=1. Both SHALL raise cs_n_o, clear busy_o and the pad enables, and hold the flag until the next start or reset.
REQ-013 mode_i falling to 0 mid-load SHALL abort: go to ERR within one cycle, with cfg_valid_o deasserted.
REQ-014 cfg_valid_o SHALL be 0 in every state except PUSH.

Reset
REQ-015 rst_i SHALL asynchronously force the following values, including mid-load, with no further SPI edge and no cfg transfer after assertion:
- state IDLE
- sclk_o=0, cs_n_o=1, mosi_o=0
- all pad enables=0
- busy_o=0, configured_o=0, error_o=0
- cfg_valid_o=0, cfg_data_o=0
REQ-016 After rst_i deasserts, a trigger_i already high SHALL NOT start a load; only a fresh 0->1 edge starts one.

Configuration
REQ-017 Macro FPGA_CFG_CHECKSUM_EN SHALL select checksum checking.
REQ-018 With FPGA_CFG_CHECKSUM_EN defined:
- The block SHALL keep a 32-bit modulo-2^32 sum of all N data words.
- CHK SHALL read one further word from flash.
- It goes to DONE if that word equals the two's complement of the sum, otherwise to ERR.
REQ-019 Without FPGA_CFG_CHECKSUM_EN: no accumulator and no CHK state; after the last transfer the block goes directly to DONE.
REQ-020 The CHK step in REQ-011 applies only with the macro defined.

Structure
REQ-021 Package fpga_cfg_pkg SHALL hold:
- the state enum
- READ_OPCODE=8'h03
- HDR_MAGIC=16'hFC25
- WORD_W=32
REQ-022 Sub-module fpga_cfg_spi_shifter SHALL implement one 32-bit full-duplex mode-0 transfer:
- inputs start, tx word, CLK_DIV
- outputs done pulse, rx word
- it has a hold input used for REQ-010.

Verification
REQ-023 Slot 3, CLK_DIV=2, header 0xFC250004, four words, ready always 1:
- MOSI carries 0x03300000.
- Exactly 4 transfers occur.
- configured_o=1, busy_o=0.
- cs_n_o stays low for exactly 6x32 SCLK periods, or 7x32 with checksum enabled.
REQ-024 Header 0x12340004 -> error_o=1, no cfg_valid_o, cs_n_o high after 64 SCLKs.
REQ-025 cfg_ready_i held 0 for 50 cycles on word 2:
- cfg_data_o stays stable and sclk_o stays low during the stall.
- The load then completes with the correct data order.
REQ-026 rst_i asserted at word 1 of 4 -> same-cycle idle outputs; a later trigger reloads correctly.
REQ-027 Checksum enabled:
- Words 1,2,3 with trailer 0xFFFFFFFA -> configured_o=1.
- Trailer 0xFFFFFFFB -> error_o=1.
REQ-028 Second trigger mid-load ignored; mode_i dropped mid-DATA -> error_o=1 and cs_n_o high next cycle.
